// File: rtl/startup_pkg.sv
// Shared types and helpers for the configuration-startup sequencer.
package startup_pkg;

  localparam int unsigned PhaseW = 3;

  typedef enum logic [PhaseW-1:0] {
    StIdle = 3'd0,
    StLock = 3'd1,
    StGts  = 3'd2,
    StGsr  = 3'd3,
    StDone = 3'd4,
    StEos  = 3'd5,
    StErr  = 3'd6
  } state_e;

  // Minimum counter width able to represent the largest cycle parameter.
  function automatic int unsigned req_cnt_w(input int unsigned gts_c, input int unsigned gsr_c,
                                            input int unsigned done_c, input int unsigned lock_t);
    int unsigned m;
    int unsigned w;
    m = gts_c;
    if (gsr_c > m) m = gsr_c;
    if (done_c > m) m = done_c;
    if (lock_t > m) m = lock_t;
    w = 1;
    while ((w < 32) && ((m >> w) != 0)) w++;
    return w;
  endfunction

endpackage

// File: rtl/startup_phase_cnt.sv
// Clearable phase counter that saturates at a runtime limit and flags reaching it.
module startup_phase_cnt #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             at_limit
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign at_limit = (cnt_q == limit);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !at_limit && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/startup_seq.sv
// Configuration-startup sequencer: waits for lock, releases GTS then GSR,
// raises DONE/EOS, then follows user GSR/GTS requests. Lock watchdog traps to error.
module startup_seq
  import startup_pkg::*;
#(
  parameter int unsigned N_LOCK       = 2,
  parameter int unsigned N_USR        = 1,
  parameter int unsigned GTS_CYCLES   = 4,
  parameter int unsigned GSR_CYCLES   = 3,
  parameter int unsigned DONE_CYCLES  = 2,
  parameter int unsigned LOCK_TIMEOUT = 16,
  parameter int unsigned CNT_W        = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [N_LOCK-1:0] locked,
  input  logic [N_USR-1:0]  usr_done,
  input  logic              gsr_req,
  input  logic              gts_req,
  output logic              gts_out,
  output logic              gsr_out,
  output logic              done,
  output logic              eos,
  output logic [PhaseW-1:0] phase,
  output logic              timeout_err
);

  localparam int unsigned ReqW = req_cnt_w(GTS_CYCLES, GSR_CYCLES, DONE_CYCLES, LOCK_TIMEOUT);

  if (CNT_W < ReqW) begin : g_cnt_w_check
    $error("startup_seq: CNT_W too narrow for the cycle parameters");
  end
  if (N_LOCK < 1 || N_USR < 1 || GTS_CYCLES < 1 || GSR_CYCLES < 1 || DONE_CYCLES < 1)
  begin : g_param_check
    $error("startup_seq: illegal zero-sized parameter");
  end

  localparam logic [CNT_W-1:0] GtsLim  = CNT_W'(GTS_CYCLES - 1);
  localparam logic [CNT_W-1:0] GsrLim  = CNT_W'(GSR_CYCLES - 1);
  localparam logic [CNT_W-1:0] DoneLim = CNT_W'(DONE_CYCLES - 1);
  // With the watchdog disabled the lock limit is parked at all-ones and never acted on.
  localparam logic [CNT_W-1:0] LockLim =
      (LOCK_TIMEOUT == 0) ? {CNT_W{1'b1}} : CNT_W'(LOCK_TIMEOUT - 1);

  state_e state_q, state_d;
  logic   gts_q, gts_d;
  logic   gsr_q, gsr_d;
  logic   done_q, done_d;
  logic   eos_q, eos_d;
  logic   err_q, err_d;

  logic             cnt_clr;
  logic             cnt_en;
  logic [CNT_W-1:0] cnt_limit;
  logic             at_limit;

  startup_phase_cnt #(
    .CNT_W(CNT_W)
  ) u_phase_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .limit   (cnt_limit),
    .at_limit(at_limit)
  );

  always_comb begin
    state_d   = state_q;
    gts_d     = gts_q;
    gsr_d     = gsr_q;
    done_d    = done_q;
    eos_d     = eos_q;
    err_d     = err_q;
    cnt_en    = 1'b0;
    cnt_limit = {CNT_W{1'b1}};

    unique case (state_q)
      StIdle: begin
        if (start) state_d = StLock;
      end
      StLock: begin
        cnt_en    = 1'b1;
        cnt_limit = LockLim;
        // Lock takes priority over a coincident watchdog expiry.
        if (&locked) begin
          state_d = StGts;
        end else if ((LOCK_TIMEOUT != 0) && at_limit) begin
          state_d = StErr;
          err_d   = 1'b1;
        end
      end
      StGts: begin
        cnt_en    = 1'b1;
        cnt_limit = GtsLim;
        if (at_limit) begin
          gts_d   = 1'b0;
          state_d = StGsr;
        end
      end
      StGsr: begin
        cnt_en    = 1'b1;
        cnt_limit = GsrLim;
        if (at_limit) begin
          gsr_d   = 1'b0;
          state_d = StDone;
        end
      end
      StDone: begin
        cnt_en    = 1'b1;
        cnt_limit = DoneLim;
        if (at_limit && (&usr_done)) begin
          done_d  = 1'b1;
          state_d = StEos;
        end
      end
      StEos: begin
        eos_d = 1'b1;
        gsr_d = gsr_req;
        gts_d = gts_req;
      end
      StErr: begin
        gts_d  = 1'b1;
        gsr_d  = 1'b1;
        done_d = 1'b0;
        eos_d  = 1'b0;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    cnt_clr = (state_d != state_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      gts_q   <= 1'b1;
      gsr_q   <= 1'b1;
      done_q  <= 1'b0;
      eos_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gts_q   <= gts_d;
      gsr_q   <= gsr_d;
      done_q  <= done_d;
      eos_q   <= eos_d;
      err_q   <= err_d;
    end
  end

  assign gts_out     = gts_q;
  assign gsr_out     = gsr_q;
  assign done        = done_q;
  assign eos         = eos_q;
  assign phase       = state_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_startup_seq.sv
// Scoreboard bench for startup_seq: driver queues hand-derived expectations per edge,
// a negedge monitor pops and compares them.
module tb_startup_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] locked = 2'b00;
  logic [0:0] usr_done = 1'b0;
  logic       gsr_req = 1'b0;
  logic       gts_req = 1'b0;
  logic       gts_out, gsr_out, done, eos, timeout_err;
  logic [2:0] phase;

  startup_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .locked     (locked),
    .usr_done   (usr_done),
    .gsr_req    (gsr_req),
    .gts_req    (gts_req),
    .gts_out    (gts_out),
    .gsr_out    (gsr_out),
    .done       (done),
    .eos        (eos),
    .phase      (phase),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [2:0] phase;
    logic       gts;
    logic       gsr;
    logic       done;
    logic       eos;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic exp_t mk(string n, int ph, bit g, bit s, bit d, bit o, bit r);
    exp_t e;
    e.name  = n;
    e.phase = 3'(ph);
    e.gts   = g;
    e.gsr   = s;
    e.done  = d;
    e.eos   = o;
    e.err   = r;
    return e;
  endfunction

  function automatic exp_t idle(string n);
    return mk(n, 0, 1, 1, 0, 0, 0);
  endfunction

  // Outputs after edge k of an uninterrupted default-parameter sequence.
  function automatic exp_t nom(string n, int k);
    int ph;
    if (k == 0) ph = 1;
    else if (k < 5) ph = 2;
    else if (k < 8) ph = 3;
    else if (k < 10) ph = 4;
    else ph = 5;
    return mk(n, ph, k < 5, k < 8, k >= 10, k >= 11, 0);
  endfunction

  task automatic tick(exp_t e);
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    start    = 1'b0;
    locked   = 2'b00;
    usr_done = 1'b0;
    gsr_req  = 1'b0;
    gts_req  = 1'b0;
    tick(idle("reset_a"));
    tick(idle("reset_b"));
    rst_n = 1'b1;
    tick(idle("idle_hold"));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if ({phase, gts_out, gsr_out, done, eos, timeout_err} !==
          {e.phase, e.gts, e.gsr, e.done, e.eos, e.err}) begin
        n_bad++;
        $display("FAIL %s @%0t: got ph=%0d gts=%b gsr=%b done=%b eos=%b err=%b, want ph=%0d gts=%b gsr=%b done=%b eos=%b err=%b",
                 e.name, $time, phase, gts_out, gsr_out, done, eos, timeout_err,
                 e.phase, e.gts, e.gsr, e.done, e.eos, e.err);
      end
    end
  end

  initial begin
    do_reset();

    // Nominal sequence; START re-raised after EOS must be ignored.
    locked = 2'b11; usr_done = 1'b1; start = 1'b1;
    for (int k = 0; k < 14; k++) begin
      tick(nom("nominal", k));
      start = (k >= 11);
    end

    // Lock watchdog, then late lock is ignored in the error state.
    do_reset();
    locked = 2'b01; usr_done = 1'b1; start = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick(mk("lock_wait", 1, 1, 1, 0, 0, 0));
      start = 1'b0;
    end
    tick(mk("timeout", 6, 1, 1, 0, 0, 1));
    locked = 2'b11;
    for (int k = 0; k < 4; k++) tick(mk("err_hold", 6, 1, 1, 0, 0, 1));

    // DONE waits on USR_DONE.
    do_reset();
    locked = 2'b11; usr_done = 1'b0; start = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (k < 8) tick(nom("pre_done", k));
      else tick(mk("done_wait", 4, 0, 0, 0, 0, 0));
      start = 1'b0;
      if (k == 19) usr_done = 1'b1;
    end
    tick(mk("done_rise", 5, 0, 0, 1, 0, 0));
    tick(mk("eos_rise", 5, 0, 0, 1, 1, 0));

    // Post-EOS GSR/GTS requests.
    do_reset();
    locked = 2'b11; usr_done = 1'b1; start = 1'b1;
    for (int k = 0; k < 13; k++) begin
      tick(nom("pre_eos", k));
      start = 1'b0;
    end
    gsr_req = 1'b1; gts_req = 1'b1;
    tick(mk("req_both_a", 5, 1, 1, 1, 1, 0));
    tick(mk("req_both_b", 5, 1, 1, 1, 1, 0));
    gsr_req = 1'b0;
    tick(mk("req_gts_a", 5, 1, 0, 1, 1, 0));
    tick(mk("req_gts_b", 5, 1, 0, 1, 1, 0));
    gts_req = 1'b0;
    tick(mk("req_none_a", 5, 0, 0, 1, 1, 0));
    tick(mk("req_none_b", 5, 0, 0, 1, 1, 0));

    // Reset in S_GSR, then replay.
    do_reset();
    locked = 2'b11; usr_done = 1'b1; start = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick(nom("pre_abort", k));
      start = 1'b0;
    end
    rst_n = 1'b0;
    tick(idle("mid_reset"));
    rst_n = 1'b1;
    tick(idle("post_reset"));
    start = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick(nom("replay", k));
      start = 1'b0;
    end

    // Lock arriving on the timeout edge wins.
    do_reset();
    locked = 2'b01; usr_done = 1'b1; start = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick(mk("lock_wait2", 1, 1, 1, 0, 0, 0));
      start = 1'b0;
      if (k == 15) locked = 2'b11;
    end
    for (int k = 16; k < 28; k++) tick(nom("late_lock", k - 15));

    @(negedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/startup_seq.md
Name: startup_seq

Overview:
Parametrised configuration-startup sequencer for the device-primitive library. It waits for N_LOCK clock-manager lock inputs, then releases global tristate (GTS) and global set/reset (GSR) in order after programmable delays. It then asserts DONE once all N_USR user-done inputs agree, and raises end-of-startup (EOS) one cycle later. After EOS, user requests can re-assert GSR/GTS; a lock watchdog traps into an error state.

Parameters:
N_LOCK, 2, number of LOCKED inputs (>=1)
N_USR, 1, number of USR_DONE inputs (>=1)
GTS_CYCLES, 4, cycles spent in S_GTS before GTS release (>=1)
GSR_CYCLES, 3, cycles spent in S_GSR before GSR release (>=1)
DONE_CYCLES, 2, minimum cycles in S_DONE before DONE may assert (>=1)
LOCK_TIMEOUT, 16, max cycles in S_LOCK; 0 disables the watchdog
CNT_W, 8, phase counter width; must hold max(all cycle parameters)

Ports:
CLK  in  1  sole clock, rising edge
RST_N  in  1  synchronous active-low reset
START  in  1  begin sequence; sampled only in S_IDLE
LOCKED  in  N_LOCK  clock-manager lock flags
USR_DONE  in  N_USR  user done-release enables
GSR_REQ  in  1  post-EOS user request to re-assert GSR
GTS_REQ  in  1  post-EOS user request to re-assert GTS
GTS_OUT  out  1  global tristate, active high
GSR_OUT  out  1  global set/reset, active high
DONE  out  1  configuration done
EOS  out  1  end of startup
PHASE  out  3  current state encoding
TIMEOUT_ERR  out  1  lock watchdog expired (sticky)

Behaviour:
- Reset (RST_N low at an edge): state S_IDLE, counter 0. GTS_OUT=1, GSR_OUT=1, DONE=0, EOS=0, TIMEOUT_ERR=0. Reset mid-sequence aborts the sequence and restores these values, including from S_EOS and S_ERR.
- All outputs are registered. PHASE encodes the state: S_IDLE=0, S_LOCK=1, S_GTS=2, S_GSR=3, S_DONE=4, S_EOS=5, S_ERR=6.
- S_IDLE: START=1 -> S_LOCK, counter cleared.
- S_LOCK:
  - &LOCKED=1 -> S_GTS, counter cleared.
  - Otherwise, with LOCK_TIMEOUT!=0 and counter==LOCK_TIMEOUT-1 -> S_ERR and TIMEOUT_ERR=1.
  - Lock arriving on the same cycle as the timeout wins (go to S_GTS).
- S_GTS: counter increments each cycle. When counter==GTS_CYCLES-1: GTS_OUT<=0, go to S_GSR, counter cleared.
- S_GSR: when counter==GSR_CYCLES-1: GSR_OUT<=0, go to S_DONE, counter cleared.
- S_DONE:
  - Counter increments and saturates at DONE_CYCLES-1.
  - When counter==DONE_CYCLES-1 and &USR_DONE=1: DONE<=1, go to S_EOS.
  - Otherwise hold indefinitely; there is no timeout.
- S_EOS:
  - EOS<=1 on the first edge in this state; DONE and EOS stay at 1 until reset.
  - Each cycle, GSR_OUT<=GSR_REQ and GTS_OUT<=GTS_REQ (one-cycle latency); START is ignored.
- S_ERR: GTS_OUT=1, GSR_OUT=1, DONE=0, EOS=0; only reset exits.
- Loss of lock after leaving S_LOCK is ignored.
- Counter arithmetic is unsigned CNT_W and never wraps in any state.

Decomposition:
- Shared package startup_pkg holds:
  - the state enum (3-bit, with the encodings above);
  - the PHASE width constant;
  - a function computing the required CNT_W, used by an elaboration-time assertion that all cycle parameters fit.
- One natural sub-module, startup_phase_cnt: a clearable, saturating CNT_W counter with a terminal-compare output against a runtime limit.

Test Plan (defaults; edge 0 = first edge with START=1 in S_IDLE, LOCKED=2'b11, USR_DONE=1):
1. Nominal sequence -> PHASE=1 after edge 0, 2 after edge 1. GTS_OUT falls after edge 5, GSR_OUT after edge 8, DONE rises after edge 10, EOS after edge 11.
2. LOCKED=2'b01 held -> PHASE=1 for 16 cycles, then PHASE=6 and TIMEOUT_ERR=1 after edge 16. GTS_OUT/GSR_OUT stay 1; raising LOCKED later has no effect.
3. USR_DONE=0 until edge 20 -> DONE stays 0 with PHASE=4 through edge 19. DONE=1 after edge 20, EOS=1 after edge 21.
4. Post-EOS GSR_REQ pulse of 2 cycles -> GSR_OUT=1 for exactly 2 cycles, delayed 1 cycle. GTS_REQ held 1 -> GTS_OUT=1 until it drops; DONE and EOS are unaffected.
5. RST_N=0 at edge 6 (in S_GSR) -> after that edge PHASE=0, GTS_OUT=1, GSR_OUT=1. A new START replays scenario 1 timing.
6. LOCKED becomes 2'b11 exactly on the timeout cycle (edge 16) -> S_GTS is entered and TIMEOUT_ERR stays 0.
